// File: rtl/axis_loopback_pkg.sv
// Shared definitions for the AXI-stream loopback engine: mode encodings,
// FSM state type and the tkeep popcount helper.
package axis_loopback_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_INC  = 2'b01;
   localparam logic [1:0] MODE_GEN  = 2'b10;
   localparam logic [1:0] MODE_INV  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      GEN  = 2'd2
   } state_t;

   // Number of set bits; callers zero-extend their tkeep into v.
   function automatic logic [31:0] popcount(input logic [31:0] v);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) n = n + 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/axis_loopback_engine_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output stage.
// A word written at edge n is visible on rd_data after edge n+1. The total
// occupancy (memory plus output register) is capped at 2^EA words.
module axis_sync_fifo #(
   parameter int W  = 19,
   parameter int EA = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);

   localparam int DEPTH = 1 << EA;

   logic [W-1:0]  mem [DEPTH];
   logic [EA-1:0] wr_ptr;
   logic [EA-1:0] rd_ptr;
   logic [EA:0]   mem_cnt;
   logic [EA:0]   cnt;
   logic          out_valid;
   logic          do_wr;
   logic          do_pop;
   logic          do_load;

   assign full    = (cnt == (EA+1)'(DEPTH));
   assign empty   = !out_valid;
   assign do_wr   = wr_en && !full;
   assign do_pop  = out_valid && rd_en;
   assign do_load = (mem_cnt != '0) && (!out_valid || do_pop);

   // Storage array; no reset needed, occupancy is tracked by the counters.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy and the output register that feeds rd_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_cnt   <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         rd_data   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + EA'(1);
         if (do_load) begin
            rd_ptr    <= rd_ptr + EA'(1);
            rd_data   <= mem[rd_ptr];
            out_valid <= 1'b1;
         end else if (do_pop) begin
            out_valid <= 1'b0;
         end
         mem_cnt <= mem_cnt + (EA+1)'(do_wr) - (EA+1)'(do_load);
         cnt     <= cnt + (EA+1)'(do_wr) - (EA+1)'(do_pop);
      end
   end

endmodule

// File: rtl/axis_loopback_engine.sv
// AXI-stream loopback engine: buffers beats through a FWFT FIFO and applies
// a per-packet transform (pass / increment / invert) or generates a test
// pattern. Drives status LEDs with a heartbeat.
// Optional packet/byte statistics enabled by defining AXIS_LOOPBACK_STATS_EN.
//
//   state | meaning
//   IDLE  | one cycle between packets; samples mode into cur_mode
//   PASS  | accepts s beats, writes transformed beats until s_tlast
//   GEN   | writes GEN_LEN pattern beats, tlast on the final one
module axis_loopback_engine
   import axis_loopback_pkg::*;
#(
   parameter int EW        = 1,
   parameter int EA        = 6,
   parameter int GEN_LEN   = 16,
   parameter int CLK_FREQ  = 100000000,
   parameter int BEAT_FREQ = 5,
   parameter int LED_W     = 4,
   localparam int BYTES    = 1 << EW,
   localparam int DW       = 8 * BYTES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   output logic             s_tready,
   input  logic             s_tvalid,
   input  logic [DW-1:0]    s_tdata,
   input  logic [BYTES-1:0] s_tkeep,
   input  logic             s_tlast,
   input  logic             m_tready,
   output logic             m_tvalid,
   output logic [DW-1:0]    m_tdata,
   output logic [BYTES-1:0] m_tkeep,
   output logic             m_tlast,
   output logic [LED_W-1:0] led,
   output logic [31:0]      pkt_count,
   output logic [31:0]      byte_count
);

   localparam int FW      = 1 + BYTES + DW;
   localparam int GBW     = $clog2(GEN_LEN + 1);
   localparam int HB_RAW  = CLK_FREQ / (2 * BEAT_FREQ);
   localparam int HB_HALF = (HB_RAW < 1) ? 1 : HB_RAW;
   localparam int HBW     = $clog2(HB_HALF) + 1;

   state_t           state;
   logic [1:0]       cur_mode;
   logic [7:0]       gen_cnt;
   logic [GBW-1:0]   gen_beat;
   logic             gen_last;
   logic             gen_wr;
   logic             s_hs;
   logic             m_hs;
   logic             fifo_full;
   logic             fifo_empty;
   logic             wr_en;
   logic [FW-1:0]    wr_data;
   logic [DW-1:0]    xf_data;
   logic [DW-1:0]    gen_data;
   logic [LED_W-2:0] led_low;
   logic             hb;
   logic [HBW-1:0]   hb_cnt;

   assign s_tready = (state == PASS) && !fifo_full;
   assign s_hs     = s_tvalid && s_tready;
   assign gen_wr   = (state == GEN) && !fifo_full;
   assign gen_last = (gen_beat == GBW'(GEN_LEN - 1));
   assign m_tvalid = !fifo_empty;
   assign m_hs     = m_tvalid && m_tready;

   // Per-byte transform of the incoming beat and the generator pattern.
   always_comb begin
      xf_data  = s_tdata;
      gen_data = '0;
      for (int i = 0; i < BYTES; i++) begin
         case (cur_mode)
            MODE_INC: xf_data[8*i +: 8] = s_tdata[8*i +: 8] + 8'd1;
            MODE_INV: xf_data[8*i +: 8] = ~s_tdata[8*i +: 8];
            default:  xf_data[8*i +: 8] = s_tdata[8*i +: 8];
         endcase
         gen_data[8*i +: 8] = gen_cnt + 8'(i);
      end
      wr_en   = s_hs || gen_wr;
      wr_data = gen_wr ? {gen_last, {BYTES{1'b1}}, gen_data}
                       : {s_tlast, s_tkeep, xf_data};
   end

   // Packet sequencing: mode latch, pattern counters and state transitions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cur_mode <= MODE_PASS;
         gen_cnt  <= '0;
         gen_beat <= '0;
      end else begin
         case (state)
            IDLE: begin
               cur_mode <= mode;
               state    <= (mode == MODE_GEN) ? GEN : PASS;
            end
            PASS: begin
               if (s_hs && s_tlast) state <= IDLE;
            end
            GEN: begin
               if (!fifo_full) begin
                  gen_cnt <= gen_cnt + 8'(BYTES);
                  if (gen_last) begin
                     gen_beat <= '0;
                     state    <= IDLE;
                  end else begin
                     gen_beat <= gen_beat + GBW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   axis_sync_fifo #(
      .W  (FW),
      .EA (EA)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (fifo_full),
      .rd_en   (m_tready),
      .rd_data ({m_tlast, m_tkeep, m_tdata}),
      .empty   (fifo_empty)
   );

   // LED low bits follow the last beat that left the engine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) led_low <= '0;
      else if (m_hs) led_low <= m_tdata[LED_W-2:0];
   end

   // Heartbeat: toggle after every HB_HALF cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hb_cnt <= '0;
         hb     <= 1'b0;
      end else if (hb_cnt == HBW'(HB_HALF - 1)) begin
         hb_cnt <= '0;
         hb     <= ~hb;
      end else begin
         hb_cnt <= hb_cnt + HBW'(1);
      end
   end

   assign led = {hb, led_low};

`ifdef AXIS_LOOPBACK_STATS_EN
   // Output-side packet and byte statistics, wrapping modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_count  <= '0;
         byte_count <= '0;
      end else if (m_hs) begin
         byte_count <= byte_count + popcount(32'(m_tkeep));
         if (m_tlast) pkt_count <= pkt_count + 32'd1;
      end
   end
`else
   assign pkt_count  = '0;
   assign byte_count = '0;
`endif

endmodule

// File: tb/tb_axis_loopback_engine.sv
// Scoreboard bench for axis_loopback_engine: expected beats are queued as
// stimulus is issued, a monitor pops and compares on every m handshake.
module tb_axis_loopback_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'b00;
   logic        s_tready;
   logic        s_tvalid = 1'b0;
   logic [15:0] s_tdata = '0;
   logic [1:0]  s_tkeep = '0;
   logic        s_tlast = 1'b0;
   logic        m_tready = 1'b1;
   logic        m_tvalid;
   logic [15:0] m_tdata;
   logic [1:0]  m_tkeep;
   logic        m_tlast;
   logic [3:0]  led;
   logic [31:0] pkt_count;
   logic [31:0] byte_count;

   logic [18:0] exp_q[$];
   logic [18:0] exp_beat;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          acc_cnt = 0;

   axis_loopback_engine #(
      .EW        (1),
      .EA        (3),
      .GEN_LEN   (4),
      .CLK_FREQ  (20),
      .BEAT_FREQ (1),
      .LED_W     (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .s_tready   (s_tready),
      .s_tvalid   (s_tvalid),
      .s_tdata    (s_tdata),
      .s_tkeep    (s_tkeep),
      .s_tlast    (s_tlast),
      .m_tready   (m_tready),
      .m_tvalid   (m_tvalid),
      .m_tdata    (m_tdata),
      .m_tkeep    (m_tkeep),
      .m_tlast    (m_tlast),
      .led        (led),
      .pkt_count  (pkt_count),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] k, input logic l);
      exp_q.push_back({l, k, d});
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] k, input logic l);
      bit ok;
      int n;
      ok = 0;
      n  = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      while (!ok && n < 300) begin
         @(negedge clk);
         if (s_tready) ok = 1;
         n++;
      end
      if (ok) begin
         @(posedge clk);
         #1;
         acc_cnt++;
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: beat %h never accepted", d);
      end
      s_tvalid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic hb0;
      int   n;

      // Scoreboard monitor: pop and compare on each output handshake.
      fork
         forever begin
            @(negedge clk);
            if (!rst && m_tvalid && m_tready) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL out_beat: got %h with no beat expected", {m_tlast, m_tkeep, m_tdata});
               end else begin
                  exp_beat = exp_q.pop_front();
                  if ({m_tlast, m_tkeep, m_tdata} !== exp_beat) begin
                     n_bad++;
                     $display("FAIL out_beat: got %h expected %h", {m_tlast, m_tkeep, m_tdata}, exp_beat);
                  end
               end
            end
         end
      join_none

      // Reset state
      #1;
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_m_bus", 32'({m_tlast, m_tkeep, m_tdata}), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_pkt", pkt_count, 32'd0);
      check("rst_byte", byte_count, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Passthrough packet with first-beat latency checks
      push(16'h0102, 2'b11, 1'b0);
      push(16'h0304, 2'b11, 1'b0);
      push(16'h0506, 2'b11, 1'b0);
      push(16'h0708, 2'b11, 1'b1);
      send(16'h0102, 2'b11, 1'b0);
      check("lat_same_cycle", 32'(m_tvalid), 32'd0);
      send(16'h0304, 2'b11, 1'b0);
      check("lat_next_cycle", 32'(m_tvalid), 32'd1);
      send(16'h0506, 2'b11, 1'b0);
      send(16'h0708, 2'b11, 1'b1);
      mode = 2'b01;
      wait_drain("pass_drain");
`ifdef AXIS_LOOPBACK_STATS_EN
      check("pass_pkt", pkt_count, 32'd1);
      check("pass_byte", byte_count, 32'd8);
`else
      check("pass_pkt", pkt_count, 32'd0);
      check("pass_byte", byte_count, 32'd0);
`endif

      // Increment
      push(16'h0100, 2'b01, 1'b1);
      send(16'h00FF, 2'b01, 1'b1);
      mode = 2'b11;
      wait_drain("inc_drain");
`ifdef AXIS_LOOPBACK_STATS_EN
      check("inc_pkt", pkt_count, 32'd2);
      check("inc_byte", byte_count, 32'd9);
`endif

      // Invert, then start generating immediately
      push(16'h5AA5, 2'b11, 1'b1);
      send(16'hA55A, 2'b11, 1'b1);
      mode = 2'b10;
      push(16'h0100, 2'b11, 1'b0);
      push(16'h0302, 2'b11, 1'b0);
      push(16'h0504, 2'b11, 1'b0);
      push(16'h0706, 2'b11, 1'b1);
      push(16'h0908, 2'b11, 1'b0);
      push(16'h0B0A, 2'b11, 1'b0);
      push(16'h0D0C, 2'b11, 1'b0);
      push(16'h0F0E, 2'b11, 1'b1);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("gen_s_tready", 32'(s_tready), 32'd0);
         if (i == 6) mode = 2'b00;
      end
      wait_drain("gen_drain");

      // Backpressure: 8-deep FIFO, 10 beats offered
      m_tready = 1'b0;
      acc_cnt  = 0;
      for (int i = 0; i < 10; i++) push(16'(i), 2'b11, (i == 9));
      fork
         begin
            for (int i = 0; i < 10; i++) send(16'(i), 2'b11, (i == 9));
         end
         begin
            n = 0;
            while (acc_cnt < 8 && n < 200) begin
               @(posedge clk);
               n++;
            end
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("bp_accepted", 32'(acc_cnt), 32'd8);
            check("bp_s_tready", 32'(s_tready), 32'd0);
            @(posedge clk);
            #1;
            m_tready = 1'b1;
         end
      join
      wait_drain("bp_drain");

      // Mode switch mid-packet
      push(16'h1111, 2'b11, 1'b0);
      push(16'h2222, 2'b11, 1'b1);
      push(16'hCCCC, 2'b11, 1'b1);
      send(16'h1111, 2'b11, 1'b0);
      mode = 2'b11;
      send(16'h2222, 2'b11, 1'b1);
      send(16'h3333, 2'b11, 1'b1);
      mode = 2'b00;
      wait_drain("switch_drain");
      check("led_low", 32'(led[2:0]), 32'd4);

      // Reset mid-packet with buffered data
      m_tready = 1'b0;
      send(16'h4444, 2'b11, 1'b0);
      send(16'h5555, 2'b11, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("mid_rst_s_tready", 32'(s_tready), 32'd0);
      check("mid_rst_pkt", pkt_count, 32'd0);
      check("mid_rst_byte", byte_count, 32'd0);
      check("mid_rst_led_low", 32'(led[2:0]), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_tready = 1'b1;
      push(16'h0A0B, 2'b11, 1'b0);
      push(16'h0C0D, 2'b11, 1'b1);
      send(16'h0A0B, 2'b11, 1'b0);
      send(16'h0C0D, 2'b11, 1'b1);
      wait_drain("post_rst_drain");
      check("post_rst_led_low", 32'(led[2:0]), 32'd5);
`ifdef AXIS_LOOPBACK_STATS_EN
      check("post_rst_pkt", pkt_count, 32'd1);
      check("post_rst_byte", byte_count, 32'd4);
`else
      check("post_rst_pkt", pkt_count, 32'd0);
      check("post_rst_byte", byte_count, 32'd0);
`endif

      // Heartbeat: 20 Hz clock, 1 Hz beat -> toggle every 10 cycles
      @(negedge clk);
      hb0 = led[3];
      n = 0;
      while (led[3] == hb0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      hb0 = led[3];
      n = 0;
      while (led[3] == hb0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("hb_period", 32'(n), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
